// File: rtl/incr_stream_checker.sv
// Receive-side monitor for an incrementing data stream: acquires lock on the
// +STEP sequence, then flags and counts every sample that breaks it.
//
// state  | meaning
// -------+-------------------------------------------------------------
// SEEK   | hunting for LOCK_COUNT consecutive +STEP increments
// LOCKED | tracking the stream; mismatches pulse err_pulse and count

module incr_stream_checker #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 3,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int RW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MW = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);

  localparam logic [RW-1:0]        RUN_LOAD  = RW'(LOCK_COUNT);
  localparam logic [RW-1:0]        RUN_ONE   = RW'(1);
  localparam logic [MW-1:0]        MISS_LOAD = MW'(LOSS_COUNT);
  localparam logic [MW-1:0]        MISS_ONE  = MW'(1);
  localparam logic [WIDTH-1:0]     STEP_W    = WIDTH'(STEP);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic                 have_ref_q, have_ref_d;
  logic [RW-1:0]        run_left_q, run_left_d;
  logic [MW-1:0]        miss_left_q, miss_left_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0] match_count_q, match_count_d;
  logic                 err_pulse_q, err_pulse_d;

  logic [WIDTH-1:0] ref_plus_step;
  logic [WIDTH-1:0] data_plus_step;
  logic [WIDTH-1:0] expected_plus_step;

  // Sums are held in WIDTH-bit nets so wrap-around is explicit.
  assign ref_plus_step      = ref_q + STEP_W;
  assign data_plus_step     = data_in + STEP_W;
  assign expected_plus_step = expected_q + STEP_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEEK;
      ref_q         <= '0;
      have_ref_q    <= 1'b0;
      run_left_q    <= RUN_LOAD;
      miss_left_q   <= MISS_LOAD;
      expected_q    <= '0;
      err_count_q   <= '0;
      match_count_q <= '0;
      err_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_q         <= ref_d;
      have_ref_q    <= have_ref_d;
      run_left_q    <= run_left_d;
      miss_left_q   <= miss_left_d;
      expected_q    <= expected_d;
      err_count_q   <= err_count_d;
      match_count_q <= match_count_d;
      err_pulse_q   <= err_pulse_d;
    end
  end

  // run_left/miss_left are down-counters; lock or loss fires at terminal count.
  always_comb begin
    state_d       = state_q;
    ref_d         = ref_q;
    have_ref_d    = have_ref_q;
    run_left_d    = run_left_q;
    miss_left_d   = miss_left_q;
    expected_d    = expected_q;
    err_count_d   = err_count_q;
    match_count_d = match_count_q;
    err_pulse_d   = 1'b0;

    if (en) begin
      case (state_q)
        SEEK: begin
          ref_d      = data_in;
          have_ref_d = 1'b1;
          if (!have_ref_q) begin
            run_left_d = RUN_LOAD;
          end else if (data_in == ref_plus_step) begin
            if (run_left_q == RUN_ONE) begin
              state_d     = LOCKED;
              expected_d  = data_plus_step;
              run_left_d  = RUN_LOAD;
              miss_left_d = MISS_LOAD;
            end else begin
              run_left_d = run_left_q - RUN_ONE;
            end
          end else begin
            run_left_d = RUN_LOAD;
          end
        end

        LOCKED: begin
          expected_d = expected_plus_step;
          if (data_in == expected_q) begin
            if (match_count_q != CNT_MAX) match_count_d = match_count_q + CNT_ONE;
            miss_left_d = MISS_LOAD;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_ONE;
            if (miss_left_q == MISS_ONE) begin
              // Loss of lock: the offending sample seeds the new search.
              state_d     = SEEK;
              ref_d       = data_in;
              have_ref_d  = 1'b1;
              run_left_d  = RUN_LOAD;
              miss_left_d = MISS_LOAD;
            end else begin
              miss_left_d = miss_left_q - MISS_ONE;
            end
          end
        end

        default: state_d = SEEK;
      endcase
    end
  end

  assign locked      = (state_q == LOCKED);
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;
  assign match_count = match_count_q;
  assign expected    = expected_q;

endmodule
